// File: rtl/serial_adder_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg: FSM encoding and counter sizing for serial_adder_sub.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_sub_if.sv
// ---------------------------------------------------------------------------
// serial_adder_sub_if: start/busy/done handshake and operand/result bus.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_adder_sub_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/serial_adder_sub_fa_cell.sv
// ---------------------------------------------------------------------------
// serial_fa_cell: combinational 1-bit full adder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_fa_cell (
  input  wire logic x,
  input  wire logic y,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder_sub.sv
// ---------------------------------------------------------------------------
// serial_adder_sub: bit-serial WIDTH-bit adder/subtractor, LSB first.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adder_sub
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_adder_sub_if.slave  bus
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fa_s, fa_c;

  serial_fa_cell u_fa (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = fa_c;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // c_q is the carry into the MSB at this point.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = c_q ^ fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire
